// File: rtl/restoring_divider_nbit_pkg.sv
// Shared definitions for the restoring divider.
//   state_t : controller state encoding (ST_IDLE, ST_CALC)
//   clog2   : counter width helper, never returns less than 1
package div_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/restoring_divider_nbit_if.sv
// Start/done handshake bundle for the restoring divider.
//   start, A, B       : request and operands (controller -> divider)
//   Q, R              : quotient and remainder, hold last result
//   busy              : division in progress
//   done, div_by_zero : one-cycle result pulses
// master is the controller side, slave is the divider side.
interface restoring_divider_nbit_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (output start, A, B, input Q, R, busy, done, div_by_zero);
  modport slave  (input start, A, B, output Q, R, busy, done, div_by_zero);
endinterface

// File: rtl/restoring_divider_nbit_step.sv
// One combinational restoring-division iteration plus its full-adder cell.
// fa               : 1-bit full adder (i_a, i_b, i_cin -> o_s, o_cout)
// restoring_div_step:
//   i_pr : partial remainder (always < divisor, so N bits suffice)
//   i_wq : working quotient shift register, MSB is the next dividend bit
//   i_b  : divisor
//   o_pr : partial remainder after this iteration
//   o_wq : working quotient shifted left with the new quotient bit
module fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  assign o_s    = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module restoring_div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_pr,
  input  logic [N-1:0] i_wq,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_pr,
  output logic [N-1:0] o_wq
);
  logic [N:0]   w_t;
  logic [N:0]   w_bn;
  logic [N:0]   w_d;
  logic [N+1:0] w_c;
  logic         w_ge;

  assign w_t    = {i_pr, i_wq[N-1]};
  // Two's-complement subtract: invert the zero-extended divisor, carry in 1.
  assign w_bn   = ~{1'b0, i_b};
  assign w_c[0] = 1'b1;

  for (genvar k = 0; k <= N; k++) begin : g_sub
    fa u_fa (
      .i_a   (w_t[k]),
      .i_b   (w_bn[k]),
      .i_cin (w_c[k]),
      .o_s   (w_d[k]),
      .o_cout(w_c[k+1])
    );
  end

  // Since t < 2*B, a non-negative difference (sign bit clear) and the absence
  // of a borrow (carry out set) always agree; both mean t >= B.
  assign w_ge = ~w_d[N] & w_c[N+1];

  // Restoring choice. t < B whenever the subtraction is rejected, so t[N] is
  // zero there and only the low N bits need to be kept.
  assign o_pr = w_ge ? w_d[N-1:0] : w_t[N-1:0];
  assign o_wq = {i_wq[N-2:0], w_ge};
endmodule

// File: rtl/restoring_divider_nbit.sv
// Sequential unsigned N-bit restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset; abandons any division in flight
//   bus   : slave side of restoring_divider_nbit_if (start/A/B in,
//           Q/R/busy/done/div_by_zero out, all outputs registered)
// A nonzero divisor produces done N cycles after the accepted start; a zero
// divisor answers on the next cycle with Q = all ones, R = A.
module restoring_divider_nbit
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  restoring_divider_nbit_if.slave bus
);
  localparam int CW = clog2(N);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [N-1:0]  r_wq,    w_wq_nxt;
  logic [N-1:0]  r_pr,    w_pr_nxt;
  logic [N-1:0]  r_b,     w_b_nxt;
  logic [N-1:0]  r_q,     w_q_nxt;
  logic [N-1:0]  r_r,     w_r_nxt;
  logic          r_busy,  w_busy_nxt;
  logic          r_done,  w_done_nxt;
  logic          r_dbz,   w_dbz_nxt;

  logic [N-1:0]  w_step_pr;
  logic [N-1:0]  w_step_wq;

  restoring_div_step #(.N(N)) u_step (
    .i_pr(r_pr),
    .i_wq(r_wq),
    .i_b (r_b),
    .o_pr(w_step_pr),
    .o_wq(w_step_wq)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_wq    <= '0;
      r_pr    <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wq    <= w_wq_nxt;
      r_pr    <= w_pr_nxt;
      r_b     <= w_b_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_dbz   <= w_dbz_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wq_nxt    = r_wq;
    w_pr_nxt    = r_pr;
    w_b_nxt     = r_b;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_dbz_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.B != '0) begin
            w_wq_nxt    = bus.A;
            w_b_nxt     = bus.B;
            w_pr_nxt    = '0;
            w_cnt_nxt   = CW'(N - 1);
            w_busy_nxt  = 1'b1;
            w_state_nxt = ST_CALC;
          end else begin
            // Same answer the iteration would reach with B=0, without the wait.
            w_q_nxt    = '1;
            w_r_nxt    = bus.A;
            w_done_nxt = 1'b1;
            w_dbz_nxt  = 1'b1;
          end
        end
      end
      ST_CALC: begin
        w_wq_nxt  = w_step_wq;
        w_pr_nxt  = w_step_pr;
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == '0) begin
          w_q_nxt     = w_step_wq;
          w_r_nxt     = w_step_pr;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.Q           = r_q;
  assign bus.R           = r_r;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_restoring_divider_nbit.sv
module tb_restoring_divider_nbit;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dbz;
    int cyc;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];

  restoring_divider_nbit_if #(.N(4)) if4 ();
  restoring_divider_nbit_if #(.N(8)) if8 ();

  restoring_divider_nbit #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  restoring_divider_nbit #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (if4.done) begin
      if (sb4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done4_unexpected: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e = sb4.pop_front();
        check("q4", int'(if4.Q), e.q);
        check("r4", int'(if4.R), e.r);
        check("dbz4", int'(if4.div_by_zero), e.dbz);
        check("latency4", cyc, e.cyc);
        check("recombine4", int'(if4.Q) * e.b + int'(if4.R), e.a);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if8.done) begin
      if (sb8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done8_unexpected: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e = sb8.pop_front();
        check("q8", int'(if8.Q), e.q);
        check("r8", int'(if8.R), e.r);
        check("dbz8", int'(if8.div_by_zero), e.dbz);
        check("latency8", cyc, e.cyc);
        check("recombine8", int'(if8.Q) * e.b + int'(if8.R), e.a);
        check("rem_lt_b8", int'(int'(if8.R) < e.b), 1);
      end
    end
  end

  // Called right after a negedge; returns one negedge later with start low.
  task automatic issue4(input int a, input int b, input int qe, input int re, input int dze);
    exp_t e;
    e.a = a; e.b = b; e.q = qe; e.r = re; e.dbz = dze;
    e.cyc = cyc + 1 + ((b != 0) ? 4 : 0);
    sb4.push_back(e);
    if4.A = 4'(a);
    if4.B = 4'(b);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
  endtask

  // Waits (bounded) for done, counting busy cycles; returns on the done negedge.
  task automatic wait4(output int bc);
    int n;
    bc = 0;
    n  = 0;
    while (!if4.done && n < 20) begin
      if (if4.busy) bc++;
      @(negedge clk);
      n++;
    end
    if (!if4.done) begin
      total++;
      bad++;
      $display("FAIL timeout4: got no done expected done within 20 cycles");
    end
  endtask

  task automatic run8(input int a, input int b);
    exp_t e;
    int n;
    e.a = a; e.b = b; e.q = a / b; e.r = a % b; e.dbz = 0;
    e.cyc = cyc + 1 + 8;
    sb8.push_back(e);
    if8.A = 8'(a);
    if8.B = 8'(b);
    if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    n = 0;
    while (!if8.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!if8.done) begin
      total++;
      bad++;
      $display("FAIL timeout8: got no done expected done within 20 cycles");
    end
  endtask

  initial begin
    int bc;
    if4.start = 1'b0; if4.A = '0; if4.B = '0;
    if8.start = 1'b0; if8.A = '0; if8.B = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_q4", int'(if4.Q), 0);
    check("rst_r4", int'(if4.R), 0);
    check("rst_busy4", int'(if4.busy), 0);
    check("rst_done4", int'(if4.done), 0);
    check("rst_dbz4", int'(if4.div_by_zero), 0);
    check("rst_q8", int'(if8.Q), 0);
    check("rst_r8", int'(if8.R), 0);
    check("rst_busy8", int'(if8.busy), 0);

    // 13 / 3
    issue4(13, 3, 4, 1, 0);
    wait4(bc);
    check("busy_cycles_13_3", bc, 4);

    // 15 / 1 then 5 / 9 started on the done cycle
    @(negedge clk);
    issue4(15, 1, 15, 0, 0);
    wait4(bc);
    issue4(5, 9, 0, 5, 0);
    check("hold_q_b2b", int'(if4.Q), 15);
    check("hold_r_b2b", int'(if4.R), 0);
    wait4(bc);
    check("busy_cycles_5_9", bc, 4);

    // 7 / 0
    @(negedge clk);
    issue4(7, 0, 15, 7, 1);
    wait4(bc);
    check("busy_cycles_div0", bc, 0);

    // 14 / 4 with an ignored start two cycles later
    @(negedge clk);
    issue4(14, 4, 3, 2, 0);
    @(negedge clk);
    if4.A = 4'd1; if4.B = 4'd1; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    wait4(bc);
    repeat (8) @(negedge clk);

    // 9 / 2 abandoned by reset at the second CALC edge
    if4.A = 4'd9; if4.B = 4'd2; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_q4", int'(if4.Q), 0);
    check("midrst_r4", int'(if4.R), 0);
    check("midrst_busy4", int'(if4.busy), 0);
    check("midrst_done4", int'(if4.done), 0);
    repeat (8) @(negedge clk);
    issue4(9, 2, 4, 1, 0);
    wait4(bc);
    check("busy_cycles_9_2", bc, 4);

    // N=8: boundary vectors, then random operands
    @(negedge clk);
    run8(255, 1);
    run8(0, 7);
    run8(200, 255);
    run8(255, 255);
    run8(128, 3);
    for (int i = 0; i < 1000; i++) begin
      run8(int'($urandom_range(0, 255)), int'($urandom_range(1, 255)));
    end

    repeat (4) @(negedge clk);
    check("sb4_drained", sb4.size(), 0);
    check("sb8_drained", sb8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/restoring_divider_nbit.md
Name: restoring_divider_nbit

Overview:
Sequential unsigned N-bit integer divider, the inverse operation of the team's combinational array multiplier. It uses a restoring shift-subtract algorithm with one quotient bit per clock. A start/done handshake lets a controller or testbench launch a division and collect the quotient and remainder. It sits beside the multiplier in the arithmetic examples, and benches check it by recomputing dividend = Q*B + R through the multiplier.

Parameters:
N, 4, operand width in bits (N >= 2); quotient and remainder are both N bits

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request a division; sampled only in IDLE
A  input  N  dividend; captured on the accepted start edge
B  input  N  divisor; captured on the accepted start edge
Q  output  N  quotient; holds last result
R  output  N  remainder; holds last result
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when Q/R update
div_by_zero  output  1  one-cycle pulse, coincident with done, when the captured B was 0

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, Q=0, R=0, busy=0, done=0, div_by_zero=0, internal counter and registers cleared. Reset has priority over everything, including mid-division; the operation in flight is abandoned and produces no done.
- States: IDLE, CALC. All outputs are registered.
- IDLE:
  - start=1 and B!=0: capture A into the working quotient shift register and {1'b0,B} into the divisor register. Clear the (N+1)-bit partial remainder. Set count=N-1, busy=1, go to CALC.
  - start=1 and B==0: stay in IDLE. Next cycle Q=all ones, R=A, done=1, div_by_zero=1. This matches the natural restoring result and has 1-cycle latency.
  - start=0: hold.
- CALC, one iteration per cycle:
  - t = {pr[N-1:0], wq[N-1]}
  - d = t - {1'b0,B}, computed (N+1)-bit
  - if d[N]==0: pr=d, wq={wq[N-2:0],1}
  - else: pr=t, wq={wq[N-2:0],0}
  - count decrements each cycle.
  - On the iteration with count==0: load Q=final wq, R=final pr[N-1:0], pulse done=1, clear busy, return to IDLE.
- Latency: start sampled at edge t0. N iterations occur at edges t1..tN. done, Q and R are visible after edge tN, i.e. N cycles after start. busy is high after t0 through edge tN.
- start while busy: ignored; the operand inputs are not re-sampled.
- Back-to-back operation: start may be asserted in the same cycle done is high, because the state is IDLE. The next result follows N cycles later. Q/R keep the old values until then.
- done and div_by_zero are high for exactly one cycle per accepted start.
- Width rules:
  - Quotient never exceeds 2^N-1.
  - Remainder is always < B when B!=0.
  - A < B gives Q=0, R=A.
  - A=0 gives Q=0, R=0.
  - No overflow case exists for unsigned operands.

Decomposition:
- Shared package div_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_CALC=1'b1
  - the counter-width function clog2(N)
- One natural sub-module, restoring_div_step: a combinational single iteration.
  - Inputs: pr, wq, B.
  - Outputs: next pr, next wq.
  - Internally an (N+1)-bit ripple subtractor built from the existing fa cell (B inverted, cin=1). This reuses the multiplier's adder cell.

Test Plan:
- N=4, A=13, B=3, pulse start -> done exactly 4 cycles later with Q=4, R=1, div_by_zero=0; busy high for 4 cycles.
- N=4, A=15, B=1, then A=5, B=9 issued back-to-back with start on the done cycle -> Q=15, R=0; then Q=0, R=5, four cycles later.
- N=4, A=7, B=0 -> next cycle Q=15, R=7, done=1, div_by_zero=1; busy never asserts.
- N=4, A=14, B=4 started, then start with A=1, B=1 two cycles later -> second start ignored; result Q=3, R=2; only one done pulse.
- N=4, start A=9, B=2, rst_n=0 for one edge at the second CALC cycle -> Q=0, R=0, busy=0, no done pulse afterwards; a new start of 9/2 then gives Q=4, R=1.
- N=8, exhaustive random (A,B!=0), 1000 vectors -> Q*B+R==A and R<B each time; latency always 8 cycles.
